mem_arbiter: RTL and testbench

Byte-wide memory arbiter and sequencer between the instruction-fetch stage, the memory-access stage and the single-port synchronous RAM. It accepts whole-word fetch requests from IF and byte, halfword or word load/store requests from MEM. It serialises each request into little-endian byte accesses on the RAM port and returns an assembled, extended 32-bit result with a one-cycle done pulse. MEM has priority over IF; IF transfers can be aborted by a flush.

---
 rtl/mem_arb_pkg.sv | 44 ++++
 rtl/mem_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared codes, state type and the load-result extension helper for mem_arbiter.
package mem_arb_pkg;

  // Request codes driven on mem_req; 2'b11 is treated as no request.
  localparam logic [1:0] REQ_NONE  = 2'b00;
  localparam logic [1:0] REQ_LOAD  = 2'b01;
  localparam logic [1:0] REQ_STORE = 2'b10;

  // Access size codes driven on mem_size; 2'b11 behaves as a word.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Current owner reported on if_or_mem.
  localparam logic [1:0] OWN_IDLE = 2'b00;
  localparam logic [1:0] OWN_IF   = 2'b01;
  localparam logic [1:0] OWN_MEM  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Number of RAM bytes a request of the given size touches.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    size_bytes = 3'd1;
      SZ_H:    size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  // Sign- or zero-extend the low byte/halfword of an assembled word.
  function automatic logic [31:0] extend(input logic [1:0] size, input logic sign,
                                         input logic [31:0] word);
    case (size)
      SZ_B:    extend = {{24{sign & word[7]}}, word[7:0]};
      SZ_H:    extend = {{16{sign & word[15]}}, word[15:0]};
      default: extend = word;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Byte-serialising arbiter between IF fetches and MEM loads/stores on a
// single-port, byte-wide synchronous RAM. MEM wins ties; IF can be flushed.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic [1:0]  mem_req,
  input  logic [1:0]  mem_size,
  input  logic        mem_sign,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic [1:0]  if_or_mem,
  output logic [31:0] ram_a,
  output logic        ram_wr,
  output logic [7:0]  ram_dout,
  input  logic [7:0]  ram_din
);

  state_t      state_q, state_d;
  logic [1:0]  own_q, own_d;
  logic [31:0] addr_q, addr_d;
  logic        store_q, store_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  n_q, n_d;
  // k_q counts edges since accept: it is the next byte to issue while
  // k_q < n_q, and k_q-2 is the byte whose data is on ram_din this cycle.
  logic [2:0]  k_q, k_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] ram_a_q, ram_a_d;
  logic        ram_wr_q, ram_wr_d;
  logic [7:0]  ram_dout_q, ram_dout_d;
  logic        if_done_q, if_done_d;
  logic        mem_done_q, mem_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;

  logic [31:0] issue_addr;
  logic [1:0]  cap_idx;
  logic [31:0] buf_cap;
  logic        mem_valid;

  // Next-state and output decode for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    own_d       = own_q;
    addr_d      = addr_q;
    store_d     = store_q;
    size_d      = size_q;
    sign_d      = sign_q;
    wdata_d     = wdata_q;
    n_d         = n_q;
    k_d         = k_q;
    buf_d       = buf_q;
    ram_a_d     = ram_a_q;
    ram_wr_d    = 1'b0;
    ram_dout_d  = ram_dout_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;

    // Address arithmetic wraps naturally at 32 bits.
    issue_addr = addr_q + {29'd0, k_q};
    cap_idx    = 2'(k_q - 3'd2);
    buf_cap    = buf_q;
    buf_cap[{cap_idx, 3'b000} +: 8] = ram_din;
    mem_valid  = (mem_req == REQ_LOAD) || (mem_req == REQ_STORE);

    case (state_q)
      ST_IDLE: begin
        if (mem_valid) begin
          own_d    = OWN_MEM;
          addr_d   = mem_addr;
          store_d  = (mem_req == REQ_STORE);
          size_d   = mem_size;
          sign_d   = mem_sign;
          wdata_d  = mem_wdata;
          n_d      = size_bytes(mem_size);
          k_d      = 3'd1;
          buf_d    = 32'd0;
          ram_a_d  = mem_addr;
          state_d  = ST_RUN;
          if (mem_req == REQ_STORE) begin
            ram_wr_d   = 1'b1;
            ram_dout_d = mem_wdata[7:0];
          end
        end else if (if_req && !if_flush) begin
          own_d    = OWN_IF;
          addr_d   = if_addr;
          store_d  = 1'b0;
          size_d   = SZ_W;
          sign_d   = 1'b0;
          wdata_d  = 32'd0;
          n_d      = 3'd4;
          k_d      = 3'd1;
          buf_d    = 32'd0;
          ram_a_d  = if_addr;
          state_d  = ST_RUN;
        end
      end

      ST_RUN: begin
        if ((own_q == OWN_IF) && if_flush) begin
          // Abandon the fetch silently; any bytes in flight are discarded.
          state_d = ST_IDLE;
          own_d   = OWN_IDLE;
        end else if (store_q) begin
          if (k_q == n_q) begin
            mem_done_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            ram_a_d    = issue_addr;
            ram_wr_d   = 1'b1;
            ram_dout_d = wdata_q[{k_q[1:0], 3'b000} +: 8];
            k_d        = k_q + 3'd1;
          end
        end else begin
          if (k_q < n_q) begin
            ram_a_d = issue_addr;
          end
          if (k_q >= 3'd2) begin
            buf_d = buf_cap;
          end
          k_d = k_q + 3'd1;
          // The last byte arrives two edges after its address was issued.
          if (k_q == (n_q + 3'd1)) begin
            state_d = ST_DONE;
            if (own_q == OWN_IF) begin
              if_data_d = buf_cap;
              if_done_d = 1'b1;
            end else begin
              mem_rdata_d = extend(size_q, sign_q, buf_cap);
              mem_done_d  = 1'b1;
            end
          end
        end
      end

      ST_DONE: begin
        // Requests are ignored here so requesters can drop them after done.
        state_d = ST_IDLE;
        own_d   = OWN_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        own_d   = OWN_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      own_q       <= OWN_IDLE;
      addr_q      <= 32'd0;
      store_q     <= 1'b0;
      size_q      <= SZ_B;
      sign_q      <= 1'b0;
      wdata_q     <= 32'd0;
      n_q         <= 3'd0;
      k_q         <= 3'd0;
      buf_q       <= 32'd0;
      ram_a_q     <= 32'd0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= 8'd0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      own_q       <= own_d;
      addr_q      <= addr_d;
      store_q     <= store_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      wdata_q     <= wdata_d;
      n_q         <= n_d;
      k_q         <= k_d;
      buf_q       <= buf_d;
      ram_a_q     <= ram_a_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;
  assign if_or_mem = own_q;
  assign ram_a     = ram_a_q;
  assign ram_wr    = ram_wr_q;
  assign ram_dout  = ram_dout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a 4 KiB byte RAM model on the RAM port
// and a shadow byte array from which expected results are computed.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_done;
  logic [31:0] if_data;
  logic [1:0]  mem_req;
  logic [1:0]  mem_size;
  logic        mem_sign;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [1:0]  if_or_mem;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;

  int vectors = 0;
  int miscompares = 0;
  int if_pulses = 0;
  int mem_pulses = 0;
  int wr_cycles = 0;

  logic [7:0] ram [4096];
  logic [7:0] shadow [4096];
  bit         ram_clr;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_size(mem_size), .mem_sign(mem_sign),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .if_or_mem(if_or_mem),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  // Synchronous byte RAM, aliased on the low 12 address bits.
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
    end else begin
      if (ram_wr) ram[ram_a[11:0]] <= ram_dout;
      ram_din <= ram[ram_a[11:0]];
    end
  end

  // Count pulses and write cycles over whole test segments.
  always @(posedge clk) begin
    if (if_done)  if_pulses  <= if_pulses + 1;
    if (mem_done) mem_pulses <= mem_pulses + 1;
    if (ram_wr)   wr_cycles  <= wr_cycles + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Expected read result: little-endian bytes from the shadow, then extension.
  function automatic logic [31:0] model_read(input logic [31:0] addr, input int n, input bit sign);
    longint v;
    logic [31:0] a;
    v = 0;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      v = v + (longint'(shadow[a[11:0]]) << (8 * i));
    end
    if (sign && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  // One full transaction from a single requester, with per-cycle port checks.
  task automatic txn(input bit is_if, input logic [1:0] op, input logic [1:0] size,
                     input bit sign, input logic [31:0] addr, input logic [31:0] wdata,
                     input string tag);
    int n, lat, c;
    bit is_store, seen;
    logic [31:0] exp_data, a;
    logic [1:0] own;
    is_store = !is_if && (op == REQ_STORE);
    n = is_if ? 4 : (size == SZ_B ? 1 : (size == SZ_H ? 2 : 4));
    lat = is_store ? n + 1 : n + 2;
    own = is_if ? OWN_IF : OWN_MEM;
    exp_data = model_read(addr, n, !is_if && sign);
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      mem_req = op; mem_size = size; mem_sign = sign; mem_addr = addr; mem_wdata = wdata;
    end
    c = 0; seen = 0;
    while (!seen && c < 20) begin
      tick; c++;
      seen = is_if ? if_done : mem_done;
      check({tag, "_owner"}, {30'd0, if_or_mem}, {30'd0, own});
      if (c <= n) begin
        check({tag, "_ram_a"}, ram_a, addr + 32'(c - 1));
        check({tag, "_ram_wr"}, {31'd0, ram_wr}, {31'd0, is_store});
        if (is_store) check({tag, "_ram_dout"}, {24'd0, ram_dout}, (wdata >> (8 * (c - 1))) & 32'hFF);
      end
    end
    check({tag, "_latency"}, c, lat);
    if (is_store) check({tag, "_wr_at_done"}, {31'd0, ram_wr}, 32'd0);
    else if (is_if) check({tag, "_if_data"}, if_data, exp_data);
    else check({tag, "_mem_rdata"}, mem_rdata, exp_data);
    check({tag, "_other_done"}, {31'd0, is_if ? mem_done : if_done}, 32'd0);
    if_req = 1'b0; mem_req = REQ_NONE;
    tick;
    check({tag, "_done_clear"}, {30'd0, if_done, mem_done}, 32'd0);
    check({tag, "_owner_idle"}, {30'd0, if_or_mem}, {30'd0, OWN_IDLE});
    if (is_store) begin
      for (int i = 0; i < n; i++) begin
        a = addr + 32'(i);
        shadow[a[11:0]] = 8'((wdata >> (8 * i)) & 32'hFF);
      end
      for (int i = 0; i <= n; i++) begin
        a = addr + 32'(i);
        check({tag, "_ram_byte"}, {24'd0, ram[a[11:0]]}, {24'd0, shadow[a[11:0]]});
      end
    end
  endtask

  // Wait for a done pulse while checking the owner; an expired budget shows as a latency miss.
  task automatic wait_done(input bit is_if, input int lat, input logic [1:0] own, input string tag);
    int c;
    bit seen;
    c = 0; seen = 0;
    while (!seen && c < 20) begin
      tick; c++;
      seen = is_if ? if_done : mem_done;
      check({tag, "_owner"}, {30'd0, if_or_mem}, {30'd0, own});
    end
    check({tag, "_latency"}, c, lat);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_if_done"}, {31'd0, if_done}, 32'd0);
    check({tag, "_mem_done"}, {31'd0, mem_done}, 32'd0);
    check({tag, "_ram_wr"}, {31'd0, ram_wr}, 32'd0);
    check({tag, "_owner"}, {30'd0, if_or_mem}, 32'd0);
    check({tag, "_ram_a"}, ram_a, 32'd0);
    check({tag, "_ram_dout"}, {24'd0, ram_dout}, 32'd0);
    check({tag, "_if_data"}, if_data, 32'd0);
    check({tag, "_mem_rdata"}, mem_rdata, 32'd0);
  endtask

  initial begin
    int p_if, p_mem, w0;
    bit rk;
    logic [1:0] rsz;
    logic [31:0] raddr;

    rst = 1'b1; ram_clr = 1'b1;
    if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
    mem_req = REQ_NONE; mem_size = SZ_B; mem_sign = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;
    for (int i = 0; i < 4096; i++) shadow[i] = 8'h00;
    repeat (3) tick;
    check_all_zero("reset");
    rst = 1'b0; ram_clr = 1'b0;
    tick;

    // Word fetch of a known instruction word.
    txn(0, REQ_STORE, SZ_W, 0, 32'h100, 32'h93000013, "seed_fetch");
    txn(1, REQ_NONE, SZ_W, 0, 32'h100, 32'h0, "fetch");
    check("fetch_word", if_data, 32'h93000013);

    // Signed and unsigned byte loads.
    txn(0, REQ_STORE, SZ_B, 0, 32'h20, 32'h00000080, "seed_byte");
    txn(0, REQ_LOAD, SZ_B, 1, 32'h20, 32'h0, "lb");
    check("lb_value", mem_rdata, 32'hFFFFFF80);
    txn(0, REQ_LOAD, SZ_B, 0, 32'h20, 32'h0, "lbu");
    check("lbu_value", mem_rdata, 32'h00000080);

    // Unaligned halfword store: exactly two write cycles.
    w0 = wr_cycles;
    txn(0, REQ_STORE, SZ_H, 0, 32'h41, 32'hDEADBEEF, "sh");
    check("sh_wr_cycles", wr_cycles - w0, 2);
    check("sh_byte41", {24'd0, ram[12'h041]}, 32'hEF);
    check("sh_byte42", {24'd0, ram[12'h042]}, 32'hBE);

    // Simultaneous requests: MEM first, IF at the following IDLE edge.
    txn(0, REQ_STORE, SZ_W, 0, 32'h200, 32'hCAFEF00D, "seed_sim");
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = REQ_LOAD; mem_size = SZ_W; mem_sign = 1'b0; mem_addr = 32'h200;
    wait_done(0, 6, OWN_MEM, "sim_mem");
    check("sim_mem_data", mem_rdata, 32'hCAFEF00D);
    check("sim_no_if_done", {31'd0, if_done}, 32'd0);
    mem_req = REQ_NONE;
    tick;
    check("sim_gap_owner", {30'd0, if_or_mem}, 32'd0);
    wait_done(1, 6, OWN_IF, "sim_if");
    check("sim_if_data", if_data, 32'h93000013);
    if_req = 1'b0;
    tick;

    // Flush two cycles into a fetch, with a MEM load waiting behind it.
    p_if = if_pulses; w0 = wr_cycles;
    if_req = 1'b1; if_addr = 32'h100;
    tick;
    check("flush_owner_if", {30'd0, if_or_mem}, {30'd0, OWN_IF});
    tick;
    if_flush = 1'b1; if_req = 1'b0;
    mem_req = REQ_LOAD; mem_size = SZ_B; mem_sign = 1'b1; mem_addr = 32'h20;
    tick;
    check("flush_owner_idle", {30'd0, if_or_mem}, 32'd0);
    if_flush = 1'b0;
    wait_done(0, 3, OWN_MEM, "after_flush");
    check("after_flush_data", mem_rdata, 32'hFFFFFF80);
    mem_req = REQ_NONE;
    tick;
    check("flush_no_if_done", if_pulses - p_if, 0);
    check("flush_no_write", wr_cycles - w0, 0);

    // Code 11 on mem_req and a flushed if_req are both ignored in IDLE.
    mem_req = 2'b11; if_req = 1'b1; if_addr = 32'h100; if_flush = 1'b1;
    repeat (3) tick;
    check("ignore_owner", {30'd0, if_or_mem}, 32'd0);
    check("ignore_wr", {31'd0, ram_wr}, 32'd0);
    mem_req = REQ_NONE; if_req = 1'b0; if_flush = 1'b0;
    tick;

    // Address wrap across 0xFFFFFFFF.
    txn(0, REQ_STORE, SZ_W, 0, 32'hFFFFFFFE, 32'h11223344, "wrap_st");
    txn(0, REQ_LOAD, SZ_W, 0, 32'hFFFFFFFE, 32'h0, "wrap_ld");
    check("wrap_value", mem_rdata, 32'h11223344);

    // Reset in the middle of a load.
    p_mem = mem_pulses;
    mem_req = REQ_LOAD; mem_size = SZ_W; mem_sign = 1'b0; mem_addr = 32'hFFFFFFFE;
    repeat (3) tick;
    rst = 1'b1; mem_req = REQ_NONE;
    tick;
    check_all_zero("midrst");
    rst = 1'b0;
    repeat (6) tick;
    check("midrst_no_done", mem_pulses - p_mem, 0);

    // Randomised mix of fetches, loads and stores.
    for (int t = 0; t < 40; t++) begin
      rk = ($urandom_range(0, 2) == 0);
      rsz = 2'($urandom_range(0, 3));
      raddr = ($urandom_range(0, 3) == 0) ? $urandom : 32'h400 + 32'($urandom_range(0, 31));
      if (rk) txn(1, REQ_NONE, SZ_W, 0, raddr, 32'h0, "rnd_fetch");
      else if ($urandom_range(0, 1) == 1) txn(0, REQ_STORE, rsz, 0, raddr, $urandom, "rnd_store");
      else txn(0, REQ_LOAD, rsz, 1'($urandom_range(0, 1)), raddr, 32'h0, "rnd_load");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
